// File: rtl/pcs_sync_pkg.sv
// Shared types, widths and the code-group classifier for the multi-lane PCS synchroniser.
package pcs_sync_pkg;

  localparam int CG_W   = 10;
  localparam int SUDI_W = 11;
  localparam int STAT_W = 8;

  typedef enum logic [2:0] {
    LOSS_OF_SYNC  = 3'd0,
    COMMA_DETECT  = 3'd1,
    ACQUIRE_SYNC  = 3'd2,
    SYNC_ACQUIRED = 3'd3,
    SYNC_ERR      = 3'd4
  } sync_state_e;

  typedef struct packed {
    logic comma;
    logic data;
    logic invalid;
  } cg_class_t;

  // Groups with a ones count outside 4..6 cannot be legal 8b/10b; a legal group is a comma
  // when its first seven bits (bit 9 first) carry either polarity of the comma pattern.
  function automatic cg_class_t classify_cg(input logic [CG_W-1:0] cg);
    cg_class_t  c;
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < CG_W; i++) begin
      ones = ones + {3'd0, cg[i]};
    end
    c.invalid = (ones < 4'd4) || (ones > 4'd6);
    c.comma   = !c.invalid && ((cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000));
    c.data    = !c.invalid && !c.comma;
    return c;
  endfunction

endpackage

// File: rtl/pcs_sync_lane.sv
// One lane of code-group synchronisation: classifier, sync FSM and registered SUDI output.
// With SYNC_STATS_EN defined the lane also counts SYNC_ERR -> LOSS_OF_SYNC transitions.
module pcs_sync_lane import pcs_sync_pkg::*; #(
  parameter int ACQ_COMMAS   = 3,
  parameter int GOOD_CGS_RUN = 4,
  parameter int ERR_LEVELS   = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              srst_i,
  input  logic [CG_W-1:0]   cg_i,
  input  logic              valid_i,
  output logic [SUDI_W-1:0] sudi_o,
  output logic              sudi_valid_o,
  output logic              sync_o
`ifdef SYNC_STATS_EN
  ,
  output logic [STAT_W-1:0] lost_cnt_o
`endif
);

  localparam int CC_W = $clog2(ACQ_COMMAS + 1);
  localparam int GC_W = $clog2(GOOD_CGS_RUN + 1);
  localparam int EL_W = $clog2(ERR_LEVELS + 1);

  sync_state_e       state_q, state_d;
  logic [CC_W-1:0]   comma_cnt_q, comma_cnt_d;
  logic [GC_W-1:0]   good_cnt_q, good_cnt_d;
  logic [EL_W-1:0]   err_lvl_q, err_lvl_d;
  logic              rx_even_q, rx_even_d;
  logic [SUDI_W-1:0] sudi_q;
  logic              sudi_valid_q, sync_q;
  cg_class_t         cls_s;
  logic              pos_even_s, cggood_s;

  // Next-state logic; the position of the incoming group is the toggled rx_even.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    good_cnt_d  = good_cnt_q;
    err_lvl_d   = err_lvl_q;
    rx_even_d   = rx_even_q;
    cls_s       = classify_cg(cg_i);
    pos_even_s  = ~rx_even_q;
    cggood_s    = !(cls_s.invalid | (cls_s.comma & ~pos_even_s));
    if (valid_i) begin
      rx_even_d = pos_even_s;
      case (state_q)
        LOSS_OF_SYNC: begin
          if (cls_s.comma) begin
            rx_even_d   = 1'b1;
            state_d     = COMMA_DETECT;
            comma_cnt_d = CC_W'(1);
          end else begin
            state_d = LOSS_OF_SYNC;
          end
        end
        COMMA_DETECT: begin
          if (cls_s.data) begin
            if (comma_cnt_q >= CC_W'(ACQ_COMMAS)) begin
              state_d    = SYNC_ACQUIRED;
              err_lvl_d  = '0;
              good_cnt_d = '0;
            end else begin
              state_d = ACQUIRE_SYNC;
            end
          end else begin
            state_d     = LOSS_OF_SYNC;
            comma_cnt_d = '0;
          end
        end
        ACQUIRE_SYNC: begin
          if (cls_s.comma) begin
            rx_even_d = 1'b1;
          end else begin
            rx_even_d = pos_even_s;
          end
          if (cls_s.comma && pos_even_s) begin
            state_d = COMMA_DETECT;
            if (comma_cnt_q < CC_W'(ACQ_COMMAS)) begin
              comma_cnt_d = comma_cnt_q + CC_W'(1);
            end else begin
              comma_cnt_d = comma_cnt_q;
            end
          end else if (!cggood_s) begin
            state_d     = LOSS_OF_SYNC;
            comma_cnt_d = '0;
          end else begin
            state_d = ACQUIRE_SYNC;
          end
        end
        SYNC_ACQUIRED: begin
          if (!cggood_s) begin
            state_d    = SYNC_ERR;
            err_lvl_d  = EL_W'(1);
            good_cnt_d = '0;
          end else begin
            state_d = SYNC_ACQUIRED;
          end
        end
        SYNC_ERR: begin
          if (cggood_s) begin
            if (good_cnt_q >= GC_W'(GOOD_CGS_RUN - 1)) begin
              good_cnt_d = '0;
              if (err_lvl_q <= EL_W'(1)) begin
                err_lvl_d = '0;
                state_d   = SYNC_ACQUIRED;
              end else begin
                err_lvl_d = err_lvl_q - EL_W'(1);
              end
            end else begin
              good_cnt_d = good_cnt_q + GC_W'(1);
            end
          end else begin
            good_cnt_d = '0;
            if (err_lvl_q >= EL_W'(ERR_LEVELS - 1)) begin
              state_d     = LOSS_OF_SYNC;
              err_lvl_d   = '0;
              comma_cnt_d = '0;
            end else begin
              err_lvl_d = err_lvl_q + EL_W'(1);
            end
          end
        end
        default: state_d = LOSS_OF_SYNC;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Lane state and output registers; power_on wins over any group presented on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= LOSS_OF_SYNC;
      comma_cnt_q  <= '0;
      good_cnt_q   <= '0;
      err_lvl_q    <= '0;
      rx_even_q    <= 1'b0;
      sudi_q       <= '0;
      sudi_valid_q <= 1'b0;
      sync_q       <= 1'b0;
    end else if (srst_i) begin
      state_q      <= LOSS_OF_SYNC;
      comma_cnt_q  <= '0;
      good_cnt_q   <= '0;
      err_lvl_q    <= '0;
      rx_even_q    <= 1'b0;
      sudi_q       <= '0;
      sudi_valid_q <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      comma_cnt_q  <= comma_cnt_d;
      good_cnt_q   <= good_cnt_d;
      err_lvl_q    <= err_lvl_d;
      rx_even_q    <= rx_even_d;
      sudi_valid_q <= valid_i;
      sync_q       <= (state_d == SYNC_ACQUIRED) || (state_d == SYNC_ERR);
      if (valid_i) begin
        sudi_q <= {cg_i, rx_even_d};
      end else begin
        sudi_q <= sudi_q;
      end
    end
  end

  assign sudi_o       = sudi_q;
  assign sudi_valid_o = sudi_valid_q;
  assign sync_o       = sync_q;

`ifdef SYNC_STATS_EN
  logic [STAT_W-1:0] lost_cnt_q;
  logic              lost_evt_s;

  assign lost_evt_s = valid_i && !srst_i && (state_q == SYNC_ERR) && (state_d == LOSS_OF_SYNC);

  // Loss-of-sync statistics survive power_on; only the hard reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_cnt_q <= '0;
    end else if (lost_evt_s && (lost_cnt_q != 8'hFF)) begin
      lost_cnt_q <= lost_cnt_q + 8'd1;
    end else begin
      lost_cnt_q <= lost_cnt_q;
    end
  end

  assign lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: rtl/pcs_sync_multi.sv
// Multi-lane PCS synchroniser: NUM_LANES independent lanes plus a registered all_sync flag.
// Defining SYNC_STATS_EN adds the per-lane sync_lost_cnt output.
module pcs_sync_multi import pcs_sync_pkg::*; #(
  parameter int NUM_LANES    = 4,
  parameter int ACQ_COMMAS   = 3,
  parameter int GOOD_CGS_RUN = 4,
  parameter int ERR_LEVELS   = 3
) (
  input  logic                        Clk,
  input  logic                        mr_main_reset_n,
  input  logic                        power_on,
  input  logic [NUM_LANES*CG_W-1:0]   PUDI,
  input  logic [NUM_LANES-1:0]        pudi_valid,
  output logic [NUM_LANES*SUDI_W-1:0] SUDI,
  output logic [NUM_LANES-1:0]        sudi_valid,
  output logic [NUM_LANES-1:0]        code_sync_status,
  output logic                        all_sync
`ifdef SYNC_STATS_EN
  ,
  output logic [NUM_LANES*STAT_W-1:0] sync_lost_cnt
`endif
);

  logic all_sync_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pcs_sync_lane #(
      .ACQ_COMMAS   (ACQ_COMMAS),
      .GOOD_CGS_RUN (GOOD_CGS_RUN),
      .ERR_LEVELS   (ERR_LEVELS)
    ) u_lane (
      .clk_i        (Clk),
      .rst_ni       (mr_main_reset_n),
      .srst_i       (power_on),
      .cg_i         (PUDI[i*CG_W +: CG_W]),
      .valid_i      (pudi_valid[i]),
      .sudi_o       (SUDI[i*SUDI_W +: SUDI_W]),
      .sudi_valid_o (sudi_valid[i]),
      .sync_o       (code_sync_status[i])
`ifdef SYNC_STATS_EN
      ,
      .lost_cnt_o   (sync_lost_cnt[i*STAT_W +: STAT_W])
`endif
    );
  end

  // all_sync trails the registered lane status by one cycle.
  always_ff @(posedge Clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      all_sync_q <= 1'b0;
    end else if (power_on) begin
      all_sync_q <= 1'b0;
    end else begin
      all_sync_q <= &code_sync_status;
    end
  end

  assign all_sync = all_sync_q;

endmodule

// File: tb/tb_pcs_sync_multi.sv
// Self-checking bench for pcs_sync_multi: table-driven lane sequences scored through a queue.
module tb_pcs_sync_multi;

  localparam int NL = 4;
  localparam logic [9:0] K = 10'b0011111010;
  localparam logic [9:0] D = 10'b0110110101;
  localparam logic [9:0] Z = 10'b0000000000;

  logic             Clk = 1'b0;
  logic             mr_main_reset_n;
  logic             power_on;
  logic [NL*10-1:0] PUDI;
  logic [NL-1:0]    pudi_valid;
  logic [NL*11-1:0] SUDI;
  logic [NL-1:0]    sudi_valid;
  logic [NL-1:0]    code_sync_status;
  logic             all_sync;
`ifdef SYNC_STATS_EN
  logic [NL*8-1:0]  sync_lost_cnt;
`endif

  always #5 Clk = ~Clk;

  pcs_sync_multi #(
    .NUM_LANES(NL), .ACQ_COMMAS(3), .GOOD_CGS_RUN(4), .ERR_LEVELS(3)
  ) dut (
    .Clk              (Clk),
    .mr_main_reset_n  (mr_main_reset_n),
    .power_on         (power_on),
    .PUDI             (PUDI),
    .pudi_valid       (pudi_valid),
    .SUDI             (SUDI),
    .sudi_valid       (sudi_valid),
    .code_sync_status (code_sync_status),
    .all_sync         (all_sync)
`ifdef SYNC_STATS_EN
    ,
    .sync_lost_cnt    (sync_lost_cnt)
`endif
  );

  typedef struct { logic [9:0] cg; logic v; logic ev; logic es; } vec_t;
  typedef struct { int lane; logic [12:0] exp; string nm; } sb_t;

  sb_t         sbq[$];
  logic [10:0] exp_sudi [NL];
  vec_t        acq_tab  [6];
  vec_t        main_tab [26];
  vec_t        gap_tab  [11];
  vec_t        loss_tab [3];
  int          checks   = 0;
  int          failures = 0;

  function automatic vec_t mk(logic [9:0] cg, logic v, logic ev, logic es);
    vec_t t;
    t.cg = cg; t.v = v; t.ev = ev; t.es = es;
    return t;
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic apply(int lane, vec_t t, string nm);
    sb_t e;
    PUDI[lane*10 +: 10] = t.cg;
    pudi_valid[lane]    = t.v;
    if (t.v) exp_sudi[lane] = {t.cg, t.ev};
    e.lane = lane;
    e.exp  = {exp_sudi[lane], t.v, t.es};
    e.nm   = nm;
    sbq.push_back(e);
  endtask

  task automatic tick();
    sb_t e;
    @(posedge Clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.nm, {51'd0, SUDI[e.lane*11 +: 11], sudi_valid[e.lane], code_sync_status[e.lane]},
            {51'd0, e.exp});
    end
    pudi_valid = '0;
  endtask

  task automatic run_acq(int lane, string tag);
    for (int i = 0; i < 6; i++) begin
      apply(lane, acq_tab[i], $sformatf("%s_l%0d_g%0d", tag, lane, i));
      tick();
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NL; i++) exp_sudi[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    acq_tab = '{mk(K,1,1,0), mk(D,1,0,0), mk(K,1,1,0), mk(D,1,0,0), mk(K,1,1,0), mk(D,1,0,1)};
    main_tab = '{
      mk(K,1,1,0), mk(D,1,0,0), mk(K,1,1,0), mk(D,1,0,0), mk(K,1,1,0), mk(D,1,0,1),
      mk(Z,1,1,1), mk(D,1,0,1), mk(D,1,1,1), mk(D,1,0,1), mk(D,1,1,1),
      mk(Z,1,0,1), mk(Z,1,1,1), mk(Z,1,0,0),
      mk(D,1,1,0), mk(K,1,1,0), mk(D,1,0,0), mk(D,1,1,0), mk(K,1,1,0),
      mk(D,1,0,0),
      mk(K,1,1,0), mk(D,1,0,0), mk(K,1,1,0), mk(D,1,0,0), mk(K,1,1,0), mk(D,1,0,1)};
    gap_tab = '{
      mk(K,1,1,0), mk(D,1,0,0), mk(K,1,1,0), mk(D,1,0,0),
      mk(Z,0,0,0), mk(Z,0,0,0), mk(Z,0,0,0), mk(Z,0,0,0), mk(Z,0,0,0),
      mk(K,1,1,0), mk(D,1,0,1)};
    loss_tab = '{mk(Z,1,1,1), mk(Z,1,0,1), mk(Z,1,1,0)};

    mr_main_reset_n = 1'b0;
    power_on        = 1'b0;
    PUDI            = '0;
    pudi_valid      = '0;
    clear_model();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_sudi",       {20'd0, SUDI},        64'd0);
    check("rst_sudi_valid", {60'd0, sudi_valid},  64'd0);
    check("rst_status",     {60'd0, code_sync_status}, 64'd0);
    check("rst_all_sync",   {63'd0, all_sync},    64'd0);
    mr_main_reset_n = 1'b1;

    // Lane 0: acquisition, error recovery, loss, odd comma in ACQUIRE_SYNC, reacquisition.
    for (int i = 0; i < 26; i++) begin
      apply(0, main_tab[i], $sformatf("main_g%0d", i));
      tick();
    end

    // Lane 1: idle gap between pairs 2 and 3.
    for (int i = 0; i < 11; i++) begin
      apply(1, gap_tab[i], $sformatf("gap_g%0d", i));
      tick();
    end

    run_acq(2, "acq");
    check("all_sync_lane3_idle", {63'd0, all_sync}, 64'd0);
    run_acq(3, "acq");
    check("all_sync_same_cycle", {63'd0, all_sync}, 64'd0);
    tick();
    check("all_sync_lag", {63'd0, all_sync}, 64'd1);

    // power_on overrides a valid group on the same edge.
    PUDI       = {NL{D}};
    pudi_valid = '1;
    power_on   = 1'b1;
    @(posedge Clk);
    #1;
    power_on   = 1'b0;
    pudi_valid = '0;
    clear_model();
    check("pwr_sudi",       {20'd0, SUDI},             64'd0);
    check("pwr_sudi_valid", {60'd0, sudi_valid},       64'd0);
    check("pwr_status",     {60'd0, code_sync_status}, 64'd0);
    check("pwr_all_sync",   {63'd0, all_sync},         64'd0);

    // Asynchronous reset in the middle of lane 0 acquisition.
    for (int i = 0; i < 3; i++) begin
      apply(0, acq_tab[i], $sformatf("mid_g%0d", i));
      tick();
    end
    mr_main_reset_n = 1'b0;
    #1;
    check("arst_sudi",       {20'd0, SUDI},             64'd0);
    check("arst_sudi_valid", {60'd0, sudi_valid},       64'd0);
    check("arst_status",     {60'd0, code_sync_status}, 64'd0);
    #1;
    mr_main_reset_n = 1'b1;
    clear_model();
    apply(0, mk(D,1,1,0), "post_rst_data");
    tick();
    run_acq(0, "reacq");

`ifdef SYNC_STATS_EN
    for (int n = 0; n < 2; n++) begin
      run_acq(1, $sformatf("stat_acq%0d", n));
      for (int i = 0; i < 3; i++) begin
        apply(1, loss_tab[i], $sformatf("stat_loss%0d_g%0d", n, i));
        tick();
      end
    end
    check("lost_cnt_two", {32'd0, sync_lost_cnt}, 64'h0000_0000_0000_0200);
    power_on = 1'b1;
    @(posedge Clk);
    #1;
    power_on = 1'b0;
    clear_model();
    check("lost_cnt_after_pwr", {32'd0, sync_lost_cnt}, 64'h0000_0000_0000_0200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
